// File: rtl/min_reduce_pkg.sv
// Shared types and constants for the streaming frame-minimum reducer.
package min_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;
    localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

endpackage

// File: rtl/min_int32.sv
// Combinational signed minimum: returns b only when a is strictly greater.
module min_int32 #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    assign y = (a > b) ? b : a;

endmodule

// File: rtl/min_reduce_int32_stream.sv
// Frame-minimum reducer: per frame reports minimum, first index of it and a
// saturating element count with a sticky overflow flag.
module min_reduce_int32_stream
    import min_reduce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0]        out_idx,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_ovf
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [WIDTH-1:0] out_min_q, out_min_d;
    logic [CNT_W-1:0]        out_idx_q, out_idx_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_ovf_q, out_ovf_d;

    logic signed [WIDTH-1:0] min_y;
    logic                    take_b;
    logic                    xfer;

    min_int32 #(.WIDTH(WIDTH)) u_min (
        .a (acc_q),
        .b (in_data),
        .y (min_y)
    );

    // The selector only departs from acc on a strictly smaller element.
    assign take_b    = (min_y != acc_q);
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_min_d   = out_min_q;
        out_idx_d   = out_idx_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    acc_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d = min_y;
                    if (take_b) idx_d = cnt_q;
                    if (cnt_q == CNT_SAT) ovf_d = 1'b1;
                    else                  cnt_d = cnt_q + 1'b1;
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result is captured with the last element folded in, so it is
        // already valid on the first HOLD cycle.
        if (xfer && in_last) begin
            out_min_d   = acc_d;
            out_idx_d   = idx_d;
            out_count_d = cnt_d;
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_min_q   <= '0;
            out_idx_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_min_q   <= out_min_d;
            out_idx_q   <= out_idx_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_min   = out_min_q;
    assign out_idx   = out_idx_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_min_reduce_int32_stream.sv
// Directed bench for the frame-minimum reducer (default and CNT_W=3 instances).
module tb_min_reduce_int32_stream;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [31:0] in_data, out_min;
    logic [15:0] out_idx, out_count;

    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_ovf;
    logic [31:0] s_in_data, s_out_min;
    logic [2:0]  s_out_idx, s_out_count;

    int checks = 0;
    int errors = 0;

    min_reduce_int32_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
        .out_idx(out_idx), .out_count(out_count), .out_ovf(out_ovf)
    );

    min_reduce_int32_stream #(.WIDTH(32), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_min(s_out_min),
        .out_idx(s_out_idx), .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          n;
        logic [31:0] d [8];
        logic [31:0] emin;
        int          eidx;
        int          ecnt;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // Present one element from a negedge; returns on the negedge after it transfers.
    task automatic push(input logic [31:0] d, input logic last);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("push_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called on the negedge right after the last transfer.
    task automatic get_result(input string name, input logic [31:0] emin,
                              input int eidx, input int ecnt, input logic eovf);
        int guard;
        chk({name, "_lat"}, out_valid, 1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_min"}, out_min, emin);
        chk({name, "_idx"}, out_idx, eidx[15:0]);
        chk({name, "_cnt"}, out_count, ecnt[15:0]);
        chk({name, "_ovf"}, out_ovf, eovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drop"}, out_valid, 0);
    endtask

    initial begin
        tv[0] = '{n:5, d:'{32'd5, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, 32'd2, 0, 0, 0},
                  emin:32'hFFFFFFFD, eidx:1, ecnt:5};
        tv[1] = '{n:1, d:'{32'h80000000, 0, 0, 0, 0, 0, 0, 0},
                  emin:32'h80000000, eidx:0, ecnt:1};
        tv[2] = '{n:2, d:'{32'h7FFFFFFF, 32'h7FFFFFFE, 0, 0, 0, 0, 0, 0},
                  emin:32'h7FFFFFFE, eidx:1, ecnt:2};
        tv[3] = '{n:3, d:'{32'd3, 32'd3, 32'd3, 0, 0, 0, 0, 0},
                  emin:32'd3, eidx:0, ecnt:3};
        tv[4] = '{n:5, d:'{32'hFFFFFFFF, 32'd0, 32'd1, 32'h80000001, 32'h80000000, 0, 0, 0},
                  emin:32'h80000000, eidx:4, ecnt:5};
        tv[5] = '{n:4, d:'{32'd100, 32'd50, 32'd50, 32'd20, 0, 0, 0, 0},
                  emin:32'd20, eidx:3, ecnt:4};

        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_min", out_min, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tv[v].n; i++) push(tv[v].d[i], i == tv[v].n - 1);
            get_result($sformatf("vec%0d", v), tv[v].emin, tv[v].eidx, tv[v].ecnt, 1'b0);
        end

        // Result stalled by the consumer while the next frame waits at the input.
        push(32'd9, 1'b0);
        push(32'd8, 1'b1);
        in_valid = 1'b1; in_data = 32'd6; in_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
            chk($sformatf("stall%0d_min", c), out_min, 32'd8);
            chk($sformatf("stall%0d_idx", c), out_idx, 16'd1);
            chk($sformatf("stall%0d_cnt", c), out_count, 16'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_release_valid", out_valid, 0);
        chk("stall_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        get_result("stall_next", 32'd6, 0, 1, 1'b0);

        // Gapped input with a tie on the minimum.
        push(32'd10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        push(32'd4, 1'b0);
        push(32'd4, 1'b1);
        get_result("gap", 32'd4, 1, 3, 1'b0);

        // Counter saturation on the narrow instance; the minimum is element 8.
        for (int i = 0; i < 9; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = (i == 8) ? 32'hFFFFFFFB : 32'(10 + i);
            s_in_last  = (i == 8);
            if (!s_in_ready) chk("sat_in_ready", s_in_ready, 1);
            @(negedge clk);
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        chk("sat_valid", s_out_valid, 1);
        chk("sat_min", s_out_min, 32'hFFFFFFFB);
        chk("sat_idx", s_out_idx, 3'd7);
        chk("sat_cnt", s_out_count, 3'd7);
        chk("sat_ovf", s_out_ovf, 1);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("sat_drop", s_out_valid, 0);

        // Reset mid-frame discards the partial frame.
        push(32'hFFFFFFCE, 1'b0);
        push(32'hFFFFFFC4, 1'b0);
        push(32'hFFFFFFBA, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        push(32'd1, 1'b1);
        get_result("post_rst", 32'd1, 0, 1, 1'b0);

        // Reset while holding a result clears the outputs at once.
        push(32'd77, 1'b1);
        chk("rsthold_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rsthold_valid", out_valid, 0);
        chk("rsthold_min", out_min, 0);
        chk("rsthold_cnt", out_count, 0);
        chk("rsthold_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
